// File: rtl/alu_result_stage_pkg.sv
// rtl/alu_result_stage_pkg.sv - select codes, flag indices and result entry type for the ALU result stage
package alu_result_stage_pkg;

   localparam logic [3:0] SEL_AND  = 4'h0;
   localparam logic [3:0] SEL_OR   = 4'h1;
   localparam logic [3:0] SEL_NOT  = 4'h2;
   localparam logic [3:0] SEL_NOR  = 4'h3;
   localparam logic [3:0] SEL_XOR  = 4'h4;
   localparam logic [3:0] SEL_NAND = 4'h5;
   localparam logic [3:0] SEL_MAX  = SEL_NAND;

   localparam int FLAG_COUT = 0;
   localparam int FLAG_ZERO = 1;
   localparam int FLAG_NEG  = 2;
   localparam int FLAG_OVF  = 3;

   typedef struct packed {
      logic [3:0]  sel;
      logic [31:0] y;
      logic [3:0]  flags;
   } result_entry_t;

   function automatic logic sel_is_legal(input logic [3:0] sel);
      return sel <= SEL_MAX;
   endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// rtl/alu_result_fifo.sv - small result buffer holding pointers and occupancy
module alu_result_fifo
   import alu_result_stage_pkg::*;
#(
   parameter int DEPTH = 2
)
(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_push,
   input  result_entry_t                i_entry,
   input  logic                         i_pop,
   output result_entry_t                o_head,
   output logic [$clog2(DEPTH+1)-1:0]   o_count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   result_entry_t r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
      return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

   // Storage is cleared on reset so the head reads zero while rst_n is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_entry;
            r_wr_ptr        <= ptr_next(r_wr_ptr);
         end
         if (i_pop) begin
            r_rd_ptr <= ptr_next(r_rd_ptr);
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - buffers ALU results with flag capture, sticky overflow and delivery count
module alu_result_stage
   import alu_result_stage_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int DEPTH = 2
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_sel,
   input  logic [31:0]       in_y,
   input  logic              in_cout,
   input  logic              in_neg,
   input  logic              in_ovf,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_y,
   output logic [3:0]        out_flags,
   output logic [3:0]        out_sel,
   output logic              sticky_ovf,
   input  logic              sticky_clr,
   output logic              illegal,
   output logic [CNT_W-1:0]  done_cnt
);

   localparam int OCC_W = $clog2(DEPTH + 1);

   logic              w_hs;
   logic              w_legal;
   logic              w_push;
   logic              w_pop;
   result_entry_t     w_entry;
   result_entry_t     w_head;
   logic [OCC_W-1:0]  w_count;

   logic              r_run;
   logic              r_sticky;
   logic              r_illegal;
   logic [CNT_W-1:0]  r_done;

   // r_run keeps in_ready low until the first edge after reset release.
   assign in_ready  = r_run && (w_count < OCC_W'(DEPTH));
   assign out_valid = (w_count != '0);
   assign w_hs      = in_valid && in_ready;
   assign w_legal   = sel_is_legal(in_sel);
   assign w_push    = w_hs && w_legal;
   assign w_pop     = out_valid && out_ready;

   always_comb begin
      w_entry                  = '0;
      w_entry.sel              = in_sel;
      w_entry.y                = in_y;
      w_entry.flags[FLAG_COUT] = in_cout;
      w_entry.flags[FLAG_ZERO] = (in_y == 32'h0);
      w_entry.flags[FLAG_NEG]  = in_neg;
      w_entry.flags[FLAG_OVF]  = in_ovf;
   end

   alu_result_fifo #(
      .DEPTH   (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_entry (w_entry),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_count (w_count)
   );

   assign out_y     = w_head.y;
   assign out_flags = w_head.flags;
   assign out_sel   = w_head.sel;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_run     <= 1'b0;
         r_sticky  <= 1'b0;
         r_illegal <= 1'b0;
         r_done    <= '0;
      end else begin
         r_run     <= 1'b1;
         r_illegal <= w_hs && !w_legal;
         r_sticky  <= (w_push && in_ovf) || (r_sticky && !sticky_clr);
         if (w_pop && (r_done != '1)) begin
            r_done <= r_done + 1'b1;
         end
      end
   end

   assign sticky_ovf = r_sticky;
   assign illegal    = r_illegal;
   assign done_cnt   = r_done;

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - scoreboard bench for the ALU result stage
module tb_alu_result_stage;
   import alu_result_stage_pkg::*;

   localparam int CW = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [3:0]     in_sel;
   logic [31:0]    in_y;
   logic           in_cout;
   logic           in_neg;
   logic           in_ovf;
   logic           out_valid;
   logic           out_ready;
   logic [31:0]    out_y;
   logic [3:0]     out_flags;
   logic [3:0]     out_sel;
   logic           sticky_ovf;
   logic           sticky_clr;
   logic           illegal;
   logic [CW-1:0]  done_cnt;

   int n_vec = 0;
   int n_err = 0;
   int edges;

   result_entry_t  sb[$];
   logic           exp_ill;
   logic           exp_sticky;
   logic [CW-1:0]  exp_done;

   alu_result_stage #(
      .CNT_W      (CW),
      .DEPTH      (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sel     (in_sel),
      .in_y       (in_y),
      .in_cout    (in_cout),
      .in_neg     (in_neg),
      .in_ovf     (in_ovf),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_y      (out_y),
      .out_flags  (out_flags),
      .out_sel    (out_sel),
      .sticky_ovf (sticky_ovf),
      .sticky_clr (sticky_clr),
      .illegal    (illegal),
      .done_cnt   (done_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)         edges <= 0;
      else if (edges < 4) edges <= edges + 1;
   end

   // Compare against the model first, then fold in this cycle's handshakes.
   always @(negedge clk) begin
      result_entry_t e;
      logic hs;
      logic legal;
      if (!rst_n || edges == 0) begin
         sb.delete();
         exp_ill    = 1'b0;
         exp_sticky = 1'b0;
         exp_done   = '0;
      end else begin
         check("in_ready", {31'b0, in_ready}, {31'b0, sb.size() < 2});
         check("out_valid", {31'b0, out_valid}, {31'b0, sb.size() != 0});
         check("illegal", {31'b0, illegal}, {31'b0, exp_ill});
         check("sticky_ovf", {31'b0, sticky_ovf}, {31'b0, exp_sticky});
         check("done_cnt", 32'(done_cnt), 32'(exp_done));
         if (out_valid && out_ready && sb.size() > 0) begin
            e = sb.pop_front();
            check("out_y", out_y, e.y);
            check("out_flags", {28'b0, out_flags}, {28'b0, e.flags});
            check("out_sel", {28'b0, out_sel}, {28'b0, e.sel});
            if (exp_done != '1) exp_done = exp_done + 1'b1;
         end
         hs      = in_valid && in_ready;
         legal   = (in_sel <= 4'h5);
         exp_ill = hs && !legal;
         if (hs && legal) begin
            e.sel   = in_sel;
            e.y     = in_y;
            e.flags = {in_ovf, in_neg, (in_y == 32'h0), in_cout};
            sb.push_back(e);
         end
         exp_sticky = (hs && legal && in_ovf) || (exp_sticky && !sticky_clr);
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [3:0] sel, input logic [31:0] y,
                       input logic c, input logic n, input logic o);
      bit ok;
      ok       = 1'b0;
      in_valid = 1'b1;
      in_sel   = sel;
      in_y     = y;
      in_cout  = c;
      in_neg   = n;
      in_ovf   = o;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(negedge clk);
         ok = in_ready;
      end
      if (!ok) check("send_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   initial begin
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_sel     = '0;
      in_y       = '0;
      in_cout    = 1'b0;
      in_neg     = 1'b0;
      in_ovf     = 1'b0;
      out_ready  = 1'b1;
      sticky_clr = 1'b0;

      idle(2);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_in_ready", {31'b0, in_ready}, 32'd0);
      check("rst_illegal", {31'b0, illegal}, 32'd0);
      check("rst_sticky", {31'b0, sticky_ovf}, 32'd0);
      check("rst_done", 32'(done_cnt), 32'd0);
      check("rst_out_y", out_y, 32'd0);
      check("rst_out_flags", {28'b0, out_flags}, 32'd0);
      check("rst_out_sel", {28'b0, out_sel}, 32'd0);
      rst_n = 1'b1;
      #1;
      check("ready_before_edge", {31'b0, in_ready}, 32'd0);
      idle(1);
      check("ready_after_edge", {31'b0, in_ready}, 32'd1);

      send(4'h0, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
      idle(3);
      check("done_after_first", 32'(done_cnt), 32'd1);

      out_ready = 1'b0;
      send(4'h1, 32'hA5A5_0001, 1'b1, 1'b0, 1'b0);
      send(4'h2, 32'hA5A5_0002, 1'b0, 1'b1, 1'b0);
      in_valid = 1'b1;
      in_sel   = 4'h3;
      in_y     = 32'hA5A5_0003;
      idle(3);
      check("held_ready_low", {31'b0, in_ready}, 32'd0);
      out_ready = 1'b1;
      send(4'h3, 32'hA5A5_0003, 1'b0, 1'b0, 1'b0);
      idle(4);

      send(4'h4, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
      send(4'h0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
      idle(3);

      send(4'h9, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
      check("illegal_pulse", {31'b0, illegal}, 32'd1);
      idle(1);
      check("illegal_drop", {31'b0, illegal}, 32'd0);
      check("illegal_empty", {31'b0, out_valid}, 32'd0);

      sticky_clr = 1'b1;
      send(4'h5, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);
      check("sticky_set_wins", {31'b0, sticky_ovf}, 32'd1);
      idle(1);
      check("sticky_cleared", {31'b0, sticky_ovf}, 32'd0);
      sticky_clr = 1'b0;
      idle(2);

      for (int i = 0; i < 20; i++) begin
         send(4'($urandom_range(0, 7)), $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
      end
      idle(3);

      out_ready = 1'b0;
      send(4'h1, 32'h0000_1111, 1'b0, 1'b0, 1'b0);
      send(4'h2, 32'h0000_2222, 1'b0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
      check("midrst_done", 32'(done_cnt), 32'd0);
      check("midrst_in_ready", {31'b0, in_ready}, 32'd0);
      idle(2);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      idle(1);

      for (int i = 0; i < 18; i++) begin
         send(4'(i % 6), $urandom, 1'b0, 1'b0, 1'b0);
      end
      idle(3);
      check("done_saturated", 32'(done_cnt), 32'(4'hF));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter: CNT_W, 16, width of the saturating completed-result counter.
REQ-002 Parameter: DEPTH, 2, result buffer entries (fixed at 2 for this release).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: in_valid  input  1  upstream ALU result present this cycle.
REQ-006 Port: in_ready  output  1  stage can accept a result this cycle.
REQ-007 Port: in_sel  input  4  ALU select code that produced the result.
REQ-008 Port: in_y  input  32  ALU result Y.
REQ-009 Port: in_cout, in_neg, in_ovf  input  1 each  ALU Cout, Negative, Overflow.
REQ-010 Port: out_valid  output  1  buffered result available.
REQ-011 Port: out_ready  input  1  downstream accepts result.
REQ-012 Port: out_y  output  32  head-entry result.
REQ-013 Port: out_flags  output  4  head-entry {ovf, neg, zero, cout}.
REQ-014 Port: out_sel  output  4  head-entry select code.
REQ-015 Port: sticky_ovf  output  1  overflow seen since last clear.
REQ-016 Port: sticky_clr  input  1  synchronous clear of sticky_ovf.
REQ-017 Port: illegal  output  1  one-cycle pulse: illegal select dropped.
REQ-018 Port: done_cnt  output  CNT_W  count of results delivered downstream.

Function
REQ-019 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-020 in_ready SHALL equal (occupancy < 2), from registered state only, no combinational path from out_ready.
REQ-021 out_valid SHALL equal (occupancy != 0); out_y/out_flags/out_sel SHALL show the oldest entry, stable while out_valid && !out_ready.
REQ-022 Latency: a pushed result into an empty buffer SHALL appear on out_* the next cycle.
REQ-023 Order SHALL be FIFO; pointers wrap modulo 2.
REQ-024 Push and pop in the same cycle at occupancy 1 SHALL leave occupancy 1 with the new entry at head next cycle.
REQ-025 At occupancy 2 in_ready SHALL be low; in_valid is ignored; upstream holds its data.
REQ-026 Pop at occupancy 0 SHALL be impossible (out_valid low); out_ready ignored.
REQ-027 Zero flag SHALL be recomputed at push as (in_y == 32'h0), never taken from upstream.
REQ-028 Legal select codes are 4'h0-4'h5; a handshaken result with in_sel > 4'h5 SHALL be dropped (not stored) and illegal SHALL pulse high for exactly one cycle.
REQ-029 sticky_ovf SHALL set on any stored entry with in_ovf=1; sticky_clr SHALL clear it; simultaneous set and clear SHALL leave it set.
REQ-030 done_cnt SHALL increment by 1 on each pop and saturate at all-ones.

Reset
REQ-031 While rst_n low: occupancy 0, pointers 0, out_valid 0, in_ready 0, sticky_ovf 0, illegal 0, done_cnt 0, out_y/out_flags/out_sel 0.
REQ-032 in_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-033 Reset asserted mid-transfer SHALL discard all buffered entries with no pop reported.

Structure
REQ-034 Shared package SHALL hold: select-code constants (AND 0, OR 1, NOT 2, NOR 3, XOR 4, NAND 5), SEL_MAX=5, flag bit indices (COUT 0, ZERO 1, NEG 2, OVF 3), result-entry struct {sel, y, flags}.
REQ-035 One sub-module SHALL be used: alu_result_fifo (2-entry storage, pointers, occupancy); flag, sticky and counter logic stays in the top.

Verification
REQ-036 Reset then push sel=0 y=32'h0000_0001 with out_ready=1 -> out_valid next cycle, out_y=1, out_flags=4'b0000, done_cnt=1 after pop.
REQ-037 out_ready=0, push three results -> in_ready low after second push, third held; release out_ready -> three results delivered in order.
REQ-038 Push y=32'h0 with sel=4 -> out_flags[ZERO]=1; push y=32'h8000_0000 in_neg=1 -> out_flags=4'b0100.
REQ-039 Push in_sel=4'h9 -> illegal pulses one cycle, occupancy unchanged, done_cnt unchanged.
REQ-040 Push with in_ovf=1 while sticky_clr=1 same cycle -> sticky_ovf=1; next cycle sticky_clr=1 alone -> sticky_ovf=0.
REQ-041 Fill buffer to 2, assert rst_n low mid-cycle -> out_valid drops immediately, done_cnt=0; preload done_cnt to all-ones via pops -> stays all-ones.
